dpram_fifo_ctrl: RTL

Initiator-side controller that drives the team's 8x64 dual_port_ram as a streaming FIFO.
- Producer-side valid/ready stream is written through RAM port A.
- RAM port B is read and presented as a first-word-fall-through valid/ready stream.
- Owns pointers, occupancy, read-latency tracking and a 2-entry output skid buffer.
- Sits between a producer and consumer, with the RAM instantiated beside it at the same level.

---
 rtl/dpram_fifo_ctrl_pkg.sv | 11 +
 rtl/dpram_skid_buf.sv | 49 ++++
 rtl/dpram_fifo_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dual-port-RAM FIFO controller and its output skid buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dpram_fifo_ctrl_pkg;

    // Output skid buffer depth; also the number of RAM reads that may be outstanding
    // or buffered before the controller stops issuing.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = 2;

endpackage

// File: rtl/dpram_skid_buf.sv
// Two-entry valid/ready holding buffer between the RAM read port and the consumer.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller only pushes when a slot is guaranteed free.
//
// Ports: clk/rst (sync, active-high); push/push_data write the tail; pop drops the
// head (ignored while empty); head is the oldest word (0 while empty); count = 0..2.
module dpram_skid_buf
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic [SKID_CNT_W-1:0] count
);

    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic              wr_idx;
    logic              rd_idx;
    logic              pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = (count != '0) ? mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop_ok) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Streams a producer through an 8x64 dual-port RAM (A = write, B = read) as a FWFT FIFO.
// Latency: a word accepted in cycle N (written at the following edge) is on rd_data in cycle N+3.
// Backpressure: wr_ready drops when the RAM holds 64 words; consumer stalls fill the skid first.
//
// Ports: clk, rst (sync, active-high); wr_valid/wr_ready/wr_data producer stream;
// rd_valid/rd_ready/rd_data consumer stream; level = RAM + in-flight + skid words (0..66);
// ram_* drive the RAM beside this block, ram_q_b is its registered port-B read data.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W+1:0] level,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int LVL_W = ADDR_W + 2;

    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      ram_cnt;
    logic [CNT_W-1:0]      ram_cnt_nxt;
    logic                  inflight;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [SKID_CNT_W-1:0] skid_cnt_nxt;
    logic [2:0]            slots_used;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_issue;

    assign wr_ready = (ram_cnt < CNT_W'(DEPTH));
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_valid = (skid_cnt != '0);
    assign rd_fire  = rd_valid && rd_ready;

    // Skid slots that stay claimed past this edge. Counting this cycle's pop as a
    // freed slot is what lets the 2-cycle issue-to-capture loop run at 1 word/cycle.
    assign slots_used = 3'(skid_cnt) + 3'(inflight) - 3'(rd_fire);

    // ram_cnt is the registered count, so a word being written this cycle is never
    // the target of a read issued in the same cycle.
    assign rd_issue = (ram_cnt != '0) && (slots_used < 3'(SKID_DEPTH));

    assign ram_we_a   = wr_fire;
    assign ram_addr_a = wr_ptr[ADDR_W-1:0];
    assign ram_data_a = wr_data;

    // When no read is issued, port B is parked one address past the write so an idle
    // read never lands on the location being written (its data is discarded anyway).
    assign ram_addr_b = (wr_fire && !rd_issue) ? (wr_ptr[ADDR_W-1:0] + ADDR_W'(1))
                                               : rd_ptr[ADDR_W-1:0];
    assign ram_we_b   = 1'b0;
    assign ram_data_b = '0;

    assign ram_cnt_nxt  = ram_cnt + CNT_W'(wr_fire) - CNT_W'(rd_issue);
    assign skid_cnt_nxt = skid_cnt + SKID_CNT_W'(inflight) - SKID_CNT_W'(rd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            level    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            ram_cnt  <= ram_cnt_nxt;
            inflight <= rd_issue;
            level    <= LVL_W'(ram_cnt_nxt) + LVL_W'(rd_issue) + LVL_W'(skid_cnt_nxt);
        end
    end

    // The wrapped pointer distance must always agree with the occupancy counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (CNT_W'(wr_ptr - rd_ptr) == ram_cnt);
        end
    end

    // The RAM read data is valid exactly one cycle after issue; capture it then.
    dpram_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_q_b),
        .pop       (rd_fire),
        .head      (rd_data),
        .count     (skid_cnt)
    );

endmodule
